// File: rtl/dbus_uncached_responder_pkg.sv
// Shared CPU defs for the uncached data-bus responder: FSM state encoding and AXI response codes.
package dbus_uncached_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_ADDR,
        ST_WR_RESP,
        ST_DONE
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/cpu_dbus_if.sv
// Uncached CPU data-bus: the CPU (master) presents a request and holds it while stall is high.
interface cpu_dbus_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                      read;
    logic                      write;
    logic [ADDR_WIDTH-1:0]     address;
    logic [DATA_WIDTH-1:0]     wrdata;
    logic [DATA_WIDTH/8-1:0]   byteenable;
    logic                      invalidate;
    logic                      invalidate_icache;
    logic                      stall;
    logic [DATA_WIDTH-1:0]     rddata;

    modport master (
        output read, write, address, wrdata, byteenable, invalidate, invalidate_icache,
        input  stall, rddata
    );

    modport slave (
        input  read, write, address, wrdata, byteenable, invalidate, invalidate_icache,
        output stall, rddata
    );
endinterface

// File: rtl/dbus_uncached_responder.sv
// Bridges single uncached CPU data-bus requests onto AXI-lite, one transaction at a time.
module dbus_uncached_responder
    import dbus_uncached_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    cpu_dbus_if.slave                 dbus,
    output logic [ADDR_WIDTH-1:0]     araddr,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                rresp,
    input  logic                      rvalid,
    output logic                      rready,
    output logic [ADDR_WIDTH-1:0]     awaddr,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,
    output logic                      bus_error
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BE_WIDTH-1:0]     be_q, be_d;
    logic [DATA_WIDTH-1:0]   rddata_q, rddata_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    bus_error_q, bus_error_d;

    logic req_rw, req_any;
    assign req_rw  = dbus.read || dbus.write;
    assign req_any = req_rw || dbus.invalidate || dbus.invalidate_icache;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rddata_d    = rddata_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bus_error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_rw) begin
                    addr_d  = dbus.address;
                    wdata_d = dbus.wrdata;
                    be_d    = dbus.byteenable;
                    // Write takes priority over a simultaneous read.
                    if (dbus.write) begin
                        state_d   = ST_WR_ADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = ST_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end else if (dbus.invalidate || dbus.invalidate_icache) begin
                    state_d = ST_DONE;
                end
            end
            ST_RD_ADDR: begin
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rddata_d    = rdata;
                    bus_error_d = resp_is_error(rresp);
                    state_d     = ST_DONE;
                end
            end
            ST_WR_ADDR: begin
                // AW and W complete independently; leave once both have handshaken.
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    bus_error_d = resp_is_error(bresp);
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rddata_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rddata_q    <= rddata_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Stall is raised in the request cycle itself so the CPU holds its request.
    assign dbus.stall  = !rst && ((state_q == ST_IDLE) ? req_any : (state_q != ST_DONE));
    assign dbus.rddata = rddata_q;

    assign araddr    = addr_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign awaddr    = addr_q;
    assign awvalid   = awvalid_q;
    assign wdata     = wdata_q;
    assign wstrb     = be_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;
    assign bus_error = bus_error_q;

endmodule

// File: tb/tb_dbus_uncached_responder.sv
// Bench for dbus_uncached_responder: vector table plus scoreboard, with an AXI-lite slave model of programmable delays.
module tb_dbus_uncached_responder;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_dbus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dbus_if ();

    logic [AW-1:0] araddr, awaddr;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] rdata, wdata;
    logic [1:0]    rresp, bresp;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [BW-1:0] wstrb;
    logic          bus_error;

    dbus_uncached_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .dbus(dbus_if.slave),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .bus_error(bus_error)
    );

    typedef struct {
        logic        rd, wr, inv, inv_i;
        logic [31:0] addr, wdat;
        logic [3:0]  be;
        logic [31:0] rdat;
        logic [1:0]  resp;
        int          ar_d, r_d, aw_d, w_d, b_d;
        int          exp_lat;
        logic [31:0] exp_rddata;
        logic        exp_berr;
        int          exp_arv, exp_awv, exp_wv;
    } vec_t;

    vec_t vecs[9];
    vec_t cur;
    vec_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit ar_taken, aw_taken, w_taken;
    logic [31:0] seen_araddr, seen_awaddr, seen_wdata;
    logic [3:0]  seen_wstrb;
    int cnt_arv, cnt_awv, cnt_wv, cnt_berr, cnt_unstable;
    logic prev_arv, prev_awv, prev_wv;
    logic [31:0] prev_araddr, prev_awaddr, prev_wdata;
    logic [3:0]  prev_wstrb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic clear_slave();
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        ar_taken = 0; aw_taken = 0; w_taken = 0;
        seen_araddr = '0; seen_awaddr = '0; seen_wdata = '0; seen_wstrb = '0;
        cnt_arv = 0; cnt_awv = 0; cnt_wv = 0; cnt_berr = 0; cnt_unstable = 0;
        prev_arv = 0; prev_awv = 0; prev_wv = 0;
        prev_araddr = '0; prev_awaddr = '0; prev_wdata = '0; prev_wstrb = '0;
    endtask

    function automatic vec_t mk(input logic rd, wr, inv, inv_i, input logic [31:0] addr, wdat,
                                input logic [3:0] be, input logic [31:0] rdat, input logic [1:0] resp,
                                input int ar_d, r_d, aw_d, w_d, b_d, lat, input logic [31:0] rdd,
                                input logic berr, input int arv, awv, wv);
        vec_t v;
        v.rd = rd; v.wr = wr; v.inv = inv; v.inv_i = inv_i;
        v.addr = addr; v.wdat = wdat; v.be = be; v.rdat = rdat; v.resp = resp;
        v.ar_d = ar_d; v.r_d = r_d; v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d;
        v.exp_lat = lat; v.exp_rddata = rdd; v.exp_berr = berr;
        v.exp_arv = arv; v.exp_awv = awv; v.exp_wv = wv;
        return v;
    endfunction

    // AXI-lite slave model and channel monitor, acting on the falling edge.
    initial begin
        arready = 0; rvalid = 0; rdata = '0; rresp = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;
        clear_slave();
        forever begin
            @(negedge clk);
            if (rst) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                clear_slave();
            end else begin
                if (arvalid) begin
                    cnt_arv++;
                    if (prev_arv && araddr !== prev_araddr) cnt_unstable++;
                end
                if (awvalid) begin
                    cnt_awv++;
                    if (prev_awv && awaddr !== prev_awaddr) cnt_unstable++;
                end
                if (wvalid) begin
                    cnt_wv++;
                    if (prev_wv && (wdata !== prev_wdata || wstrb !== prev_wstrb)) cnt_unstable++;
                end
                if (bus_error) cnt_berr++;
                prev_arv = arvalid; prev_awv = awvalid; prev_wv = wvalid;
                prev_araddr = araddr; prev_awaddr = awaddr; prev_wdata = wdata; prev_wstrb = wstrb;

                if (arready) arready = 0;
                else if (arvalid) begin
                    if (ar_cnt >= cur.ar_d) begin
                        arready = 1; seen_araddr = araddr; ar_taken = 1; r_cnt = 0;
                    end else ar_cnt++;
                end

                if (rvalid) begin rvalid = 0; ar_taken = 0; end
                else if (ar_taken && rready) begin
                    if (r_cnt >= cur.r_d) begin rvalid = 1; rdata = cur.rdat; rresp = cur.resp; end
                    else r_cnt++;
                end

                if (awready) awready = 0;
                else if (awvalid) begin
                    if (aw_cnt >= cur.aw_d) begin awready = 1; seen_awaddr = awaddr; aw_taken = 1; end
                    else aw_cnt++;
                end

                if (wready) wready = 0;
                else if (wvalid) begin
                    if (w_cnt >= cur.w_d) begin
                        wready = 1; seen_wdata = wdata; seen_wstrb = wstrb; w_taken = 1;
                    end else w_cnt++;
                end

                if (bvalid) begin bvalid = 0; aw_taken = 0; w_taken = 0; end
                else if (aw_taken && w_taken && bready) begin
                    if (b_cnt >= cur.b_d) begin bvalid = 1; bresp = cur.resp; end
                    else b_cnt++;
                end
            end
        end
    end

    task automatic drive_req(input vec_t v);
        dbus_if.read              = v.rd;
        dbus_if.write             = v.wr;
        dbus_if.address           = v.addr;
        dbus_if.wrdata            = v.wdat;
        dbus_if.byteenable        = v.be;
        dbus_if.invalidate        = v.inv;
        dbus_if.invalidate_icache = v.inv_i;
    endtask

    task automatic idle_req();
        dbus_if.read = 0; dbus_if.write = 0; dbus_if.invalidate = 0; dbus_if.invalidate_icache = 0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   lat;
        bit   done;
        vec_t e;
        cur = v;
        clear_slave();
        @(posedge clk); #1;
        drive_req(v);
        exp_q.push_back(v);
        lat = 0; done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (dbus_if.stall) lat++;
            else begin
                done = 1;
                e = exp_q.pop_front();
                check($sformatf("v%0d latency", idx), 32'(lat), 32'(e.exp_lat));
                check($sformatf("v%0d rddata", idx), dbus_if.rddata, e.exp_rddata);
                check($sformatf("v%0d bus_error_in_done", idx), 32'(bus_error), 32'(e.exp_berr));
            end
        end
        check($sformatf("v%0d done_reached", idx), 32'(done), 32'd1);
        if (!done) exp_q.delete();
        @(posedge clk); #1;
        idle_req();
        check($sformatf("v%0d arvalid_cycles", idx), 32'(cnt_arv), 32'(v.exp_arv));
        check($sformatf("v%0d awvalid_cycles", idx), 32'(cnt_awv), 32'(v.exp_awv));
        check($sformatf("v%0d wvalid_cycles", idx), 32'(cnt_wv), 32'(v.exp_wv));
        check($sformatf("v%0d bus_error_pulses", idx), 32'(cnt_berr), 32'(v.exp_berr));
        check($sformatf("v%0d payload_unstable", idx), 32'(cnt_unstable), 32'd0);
        if (v.wr) begin
            check($sformatf("v%0d awaddr", idx), seen_awaddr, v.addr);
            check($sformatf("v%0d wdata", idx), seen_wdata, v.wdat);
            check($sformatf("v%0d wstrb", idx), 32'(seen_wstrb), 32'(v.be));
        end else if (v.rd) begin
            check($sformatf("v%0d araddr", idx), seen_araddr, v.addr);
        end
    endtask

    initial begin
        bit   reached;
        vec_t rv;

        //         rd wr iv ii addr          wdata         be     rdata         resp  ar r aw w b lat rddata        berr arv awv wv
        vecs[0] = mk(1, 0, 0, 0, 32'h1FD0_0010, 32'h0,        4'hF,  32'hDEADBEEF, 2'b00, 0, 0, 0, 0, 0, 3, 32'hDEADBEEF, 0, 1, 0, 0);
        vecs[1] = mk(0, 1, 0, 0, 32'h1FD0_0020, 32'h12345678, 4'b0011, 32'h0,      2'b00, 0, 0, 2, 0, 0, 5, 32'hDEADBEEF, 0, 0, 3, 1);
        vecs[2] = mk(1, 0, 0, 0, 32'h1FD0_0030, 32'h0,        4'hF,  32'hCAFEF00D, 2'b10, 1, 2, 0, 0, 0, 6, 32'hCAFEF00D, 1, 2, 0, 0);
        vecs[3] = mk(0, 1, 0, 0, 32'h1FD0_0040, 32'hA5A5A5A5, 4'h0,  32'h0,        2'b11, 0, 0, 0, 3, 0, 6, 32'hCAFEF00D, 1, 0, 1, 4);
        vecs[4] = mk(1, 1, 0, 0, 32'h1FD0_0050, 32'h0F0F0F0F, 4'hF,  32'h11111111, 2'b00, 0, 0, 1, 1, 1, 5, 32'hCAFEF00D, 0, 0, 2, 2);
        vecs[5] = mk(0, 0, 1, 0, 32'h0,         32'h0,        4'h0,  32'h0,        2'b00, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0, 0, 0);
        vecs[6] = mk(0, 0, 0, 1, 32'h0,         32'h0,        4'h0,  32'h0,        2'b00, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0, 0, 0);
        vecs[7] = mk(0, 1, 0, 0, 32'h1FD0_0060, 32'h87654321, 4'hC,  32'h0,        2'b00, 0, 0, 0, 0, 0, 3, 32'hCAFEF00D, 0, 0, 1, 1);
        vecs[8] = mk(1, 0, 0, 0, 32'h1FD0_0070, 32'h0,        4'hF,  32'h00000001, 2'b01, 0, 0, 0, 0, 0, 3, 32'h00000001, 1, 1, 0, 0);

        cur = vecs[0];
        rst = 1'b1;
        idle_req();
        dbus_if.address = '0; dbus_if.wrdata = '0; dbus_if.byteenable = '0;

        // Reset state, including a request presented while reset is held.
        @(negedge clk);
        dbus_if.read = 1'b1;
        #1;
        check("reset stall", 32'(dbus_if.stall), 32'd0);
        check("reset valids/readies", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
        check("reset bus_error", 32'(bus_error), 32'd0);
        check("reset rddata", dbus_if.rddata, 32'd0);
        dbus_if.read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a read data phase.
        rv = mk(1, 0, 0, 0, 32'h1FD0_0080, 32'h0, 4'hF, 32'h55555555, 2'b00, 0, 100, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        cur = rv;
        clear_slave();
        @(posedge clk); #1;
        drive_req(rv);
        reached = 0;
        for (int c = 0; c < 20 && !reached; c++) begin
            @(negedge clk);
            if (rready) reached = 1;
        end
        check("midrd reached_rd_data", 32'(reached), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrd rready", 32'(rready), 32'd0);
        check("midrd stall", 32'(dbus_if.stall), 32'd0);
        check("midrd rddata", dbus_if.rddata, 32'd0);
        @(posedge clk); #1;
        check("midrd after_edge valids/readies", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
        idle_req();
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrd idle stall", 32'(dbus_if.stall), 32'd0);

        run_vec(100, vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
